// File: rtl/riscv_tohost_pkg.sv
// Shared definitions for the TOHOST mailbox: register byte offsets, STATUS
// bit positions, dump FSM state encoding and the STATUS word packer.
package riscv_tohost_pkg;

    // Register byte offsets on the 4-bit config bus
    localparam logic [3:0] TOHOST_SIG_BEGIN = 4'h0;
    localparam logic [3:0] TOHOST_SIG_END   = 4'h4;
    localparam logic [3:0] TOHOST_CODE      = 4'h8;
    localparam logic [3:0] TOHOST_STATUS    = 4'hC;

    // STATUS bit positions
    localparam int unsigned STATUS_FINISH   = 0;
    localparam int unsigned STATUS_PASS     = 1;
    localparam int unsigned STATUS_DONE     = 2;
    localparam int unsigned STATUS_CODE_LSB = 3;

    // Dump FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Only the low 29 code bits fit beside the three flags
    function automatic logic [31:0] status_word(input logic [28:0] code_lo,
                                                input logic        done,
                                                input logic        pass,
                                                input logic        finish);
        logic [31:0] s;
        s                     = '0;
        s[STATUS_FINISH]      = finish;
        s[STATUS_PASS]        = pass;
        s[STATUS_DONE]        = done;
        s[31:STATUS_CODE_LSB] = code_lo;
        return s;
    endfunction

endpackage

// File: rtl/riscv_tohost_regs.sv
// Register file and config-bus decode for the TOHOST mailbox.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_addr/wr/rd/wdata  config bus request (single-cycle strobes)
//   cfg_rdata, cfg_ack    registered read data and acknowledge
//   dump_done             sticky dump-complete flag from the dump FSM
//   sig_begin, sig_end    word-aligned signature bounds (SIG_AW bits)
//   sim_finish, test_pass sticky finish flag and pass flag
module riscv_tohost_regs
    import riscv_tohost_pkg::*;
#(
    parameter int unsigned SIG_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cfg_addr,
    input  logic              cfg_wr,
    input  logic              cfg_rd,
    input  logic [31:0]       cfg_wdata,
    input  logic              dump_done,
    output logic [31:0]       cfg_rdata,
    output logic              cfg_ack,
    output logic [SIG_AW-1:0] sig_begin,
    output logic [SIG_AW-1:0] sig_end,
    output logic              sim_finish,
    output logic              test_pass
);

    logic [30:0] code;
    logic [31:0] rd_mux;
    logic        wr_open;

    // Once finished the configuration is frozen until reset
    assign wr_open = cfg_wr && !sim_finish;

    // Read mux sees the pre-write state, so a same-cycle write is invisible
    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            TOHOST_SIG_BEGIN: rd_mux = 32'(sig_begin);
            TOHOST_SIG_END:   rd_mux = 32'(sig_end);
            TOHOST_CODE:      rd_mux = {code, sim_finish};
            TOHOST_STATUS:    rd_mux = status_word(code[28:0], dump_done, test_pass, sim_finish);
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata  <= '0;
            cfg_ack    <= 1'b0;
            sig_begin  <= '0;
            sig_end    <= '0;
            code       <= '0;
            sim_finish <= 1'b0;
            test_pass  <= 1'b0;
        end else begin
            cfg_ack   <= cfg_wr || cfg_rd;
            cfg_rdata <= cfg_rd ? rd_mux : '0;
            if (wr_open) begin
                case (cfg_addr)
                    TOHOST_SIG_BEGIN: sig_begin <= {cfg_wdata[SIG_AW-1:2], 2'b00};
                    TOHOST_SIG_END:   sig_end   <= {cfg_wdata[SIG_AW-1:2], 2'b00};
                    TOHOST_CODE: begin
                        // Bit 0 is the "finished" marker; without it the write is dropped
                        if (cfg_wdata[0]) begin
                            code       <= cfg_wdata[31:1];
                            sim_finish <= 1'b1;
                            test_pass  <= (cfg_wdata[31:1] == 31'd0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/riscv_tohost_mailbox.sv
// TOHOST mailbox and signature streamer. Firmware programs the signature
// bounds and a completion code; on finish the block reads each signature word
// from TCM and streams it out over valid/ready.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   cfg_*                              config bus (registered rdata/ack)
//   mem_rd_o, mem_addr_o, mem_accept_i TCM read request channel
//   mem_ack_i, mem_data_i              TCM read response
//   sig_valid_o, sig_data_o, sig_ready_i  signature word stream
//   sim_finish_o, test_pass_o, dump_done_o  status flags
module riscv_tohost_mailbox
    import riscv_tohost_pkg::*;
#(
    parameter int unsigned SIG_AW = 17
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  cfg_addr_i,
    input  logic        cfg_wr_i,
    input  logic        cfg_rd_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        cfg_ack_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        sig_valid_o,
    output logic [31:0] sig_data_o,
    input  logic        sig_ready_i,
    output logic        sim_finish_o,
    output logic        test_pass_o,
    output logic        dump_done_o
);

    logic [SIG_AW-1:0] sig_begin;
    logic [SIG_AW-1:0] sig_end;
    logic              sim_finish;
    logic              test_pass;

    logic [2:0]        state_q, state_d;
    logic [SIG_AW-1:0] ptr_q, ptr_d, ptr_next;
    logic              mem_rd_q;
    logic [31:0]       mem_addr_q;
    logic              sig_valid_q;
    logic [31:0]       sig_data_q;
    logic              dump_done_q;

    riscv_tohost_regs #(
        .SIG_AW (SIG_AW)
    ) u_regs (
        .clk        (clk_i),
        .rst        (rst_i),
        .cfg_addr   (cfg_addr_i),
        .cfg_wr     (cfg_wr_i),
        .cfg_rd     (cfg_rd_i),
        .cfg_wdata  (cfg_wdata_i),
        .dump_done  (dump_done_q),
        .cfg_rdata  (cfg_rdata_o),
        .cfg_ack    (cfg_ack_o),
        .sig_begin  (sig_begin),
        .sig_end    (sig_end),
        .sim_finish (sim_finish),
        .test_pass  (test_pass)
    );

    // ptr < sig_end and both are word aligned, so ptr + 4 cannot overflow
    assign ptr_next = ptr_q + SIG_AW'(4);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sim_finish) begin
                    ptr_d   = sig_begin;
                    state_d = (sig_begin >= sig_end) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_accept_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack_i) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (sig_ready_i) begin
                    ptr_d   = ptr_next;
                    state_d = (ptr_next >= sig_end) ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are flops decoded from the next state so they line up with it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            sig_valid_q <= 1'b0;
            sig_data_q  <= '0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_rd_q    <= (state_d == ST_REQ);
            mem_addr_q  <= 32'(ptr_d);
            sig_valid_q <= (state_d == ST_EMIT);
            dump_done_q <= (state_d == ST_DONE);
            // Responses outside WAIT are stray and must not touch the held word
            if (state_q == ST_WAIT && mem_ack_i) sig_data_q <= mem_data_i;
        end
    end

    assign mem_rd_o     = mem_rd_q;
    assign mem_addr_o   = mem_addr_q;
    assign sig_valid_o  = sig_valid_q;
    assign sig_data_o   = sig_data_q;
    assign sim_finish_o = sim_finish;
    assign test_pass_o  = test_pass;
    assign dump_done_o  = dump_done_q;

endmodule

// File: tb/tb_riscv_tohost_mailbox.sv
// Directed bench for riscv_tohost_mailbox with a one-deep TCM responder
// and a stream sink that records every accepted signature word.
module tb_riscv_tohost_mailbox;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  cfg_addr_i;
    logic        cfg_wr_i;
    logic        cfg_rd_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        cfg_ack_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        sig_valid_o;
    logic [31:0] sig_data_o;
    logic        sig_ready_i;
    logic        sim_finish_o;
    logic        test_pass_o;
    logic        dump_done_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic        pending  = 1'b0;
    logic        hold_ack = 1'b0;
    logic [31:0] paddr    = '0;
    logic [31:0] got[$];
    int unsigned n_rd = 0;

    riscv_tohost_mailbox #(
        .SIG_AW (17)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wr_i     (cfg_wr_i),
        .cfg_rd_i     (cfg_rd_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .cfg_ack_o    (cfg_ack_o),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_accept_i (mem_accept_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .sig_valid_o  (sig_valid_o),
        .sig_data_o   (sig_data_o),
        .sig_ready_i  (sig_ready_i),
        .sim_finish_o (sim_finish_o),
        .test_pass_o  (test_pass_o),
        .dump_done_o  (dump_done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h2000 && a < 32'h2010) return 32'h1111_1111 * (((a - 32'h2000) >> 2) + 1);
        return a ^ 32'hA5A5_0000;
    endfunction

    // TCM: accepts immediately, answers on the following cycle
    always begin
        @(posedge clk);
        #2;
        mem_ack_i = 1'b0;
        if (pending && !hold_ack) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_word(paddr);
            pending    = 1'b0;
        end
        mem_accept_i = mem_rd_o;
        if (mem_rd_o) begin
            pending = 1'b1;
            paddr   = mem_addr_o;
        end
    end

    // Sink / request monitor, sampled just after the falling edge
    always begin
        @(negedge clk);
        #1;
        if (sig_valid_o && sig_ready_i) got.push_back(sig_data_o);
        if (mem_rd_o) n_rd++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
        $fatal(1);
    end

    task automatic cfg_access(input logic wr, input logic rd, input logic [3:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        cfg_wr_i    = wr;
        cfg_rd_i    = rd;
        cfg_addr_i  = addr;
        cfg_wdata_i = wdata;
        @(negedge clk);
        cfg_wr_i = 1'b0;
        cfg_rd_i = 1'b0;
        rdata    = cfg_rdata_o;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] unused_rd;
        cfg_access(1'b1, 1'b0, addr, wdata, unused_rd);
    endtask

    task automatic cfg_read(input logic [3:0] addr, output logic [31:0] rdata);
        cfg_access(1'b0, 1'b1, addr, 32'h0, rdata);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        got.delete();
        n_rd = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        apply_reset();
        checks++;
        if ({cfg_ack_o, cfg_rdata_o, mem_rd_o, mem_addr_o, sig_valid_o, sig_data_o,
             sim_finish_o, test_pass_o, dump_done_o} !== 102'd0)
            $display("FAIL reset_outputs: got rd=%b addr=%h valid=%b data=%h fin=%b pass=%b done=%b required all 0",
                     mem_rd_o, mem_addr_o, sig_valid_o, sig_data_o, sim_finish_o, test_pass_o, dump_done_o);
        if ({cfg_ack_o, cfg_rdata_o, mem_rd_o, mem_addr_o, sig_valid_o, sig_data_o,
             sim_finish_o, test_pass_o, dump_done_o} !== 102'd0) errors++;
        cfg_read(4'hC, rd);
        checks++;
        if (rd !== 32'h0 || cfg_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %h ack=%b required 00000000 ack=1", rd, cfg_ack_o);
        end
    endtask

    task automatic test_pass_path();
        logic [31:0] exp [4];
        logic        done11, done12;
        logic [31:0] rd;
        exp = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        apply_reset();
        cfg_write(4'h0, 32'h2000);
        cfg_write(4'h4, 32'h2010);
        cfg_write(4'h8, 32'h1);
        checks++;
        if ({sim_finish_o, test_pass_o, cfg_ack_o} !== 3'b111) begin
            errors++;
            $display("FAIL pass_finish_n1: got fin/pass/ack=%b%b%b required 111",
                     sim_finish_o, test_pass_o, cfg_ack_o);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h2000) begin
            errors++;
            $display("FAIL pass_first_rd: got rd=%b addr=%h required rd=1 addr=00002000",
                     mem_rd_o, mem_addr_o);
        end
        done11 = 1'b0;
        done12 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 11) done11 = dump_done_o;
            if (i == 12) done12 = dump_done_o;
        end
        checks++;
        if (done11 !== 1'b0 || done12 !== 1'b1) begin
            errors++;
            $display("FAIL pass_done_timing: got done@11=%b done@12=%b required 0 and 1",
                     done11, done12);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL pass_word_count: got %0d required 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++;
                $display("FAIL pass_word%0d: got %h required %h", i,
                         (i < got.size()) ? got[i] : 32'hx, exp[i]);
            end
        end
        cfg_read(4'hC, rd);
        checks++;
        if (rd !== 32'h0000_0007 || test_pass_o !== 1'b1) begin
            errors++;
            $display("FAIL pass_status: got %h pass=%b required 00000007 pass=1", rd, test_pass_o);
        end
    endtask

    task automatic test_fail_code();
        logic [31:0] rd;
        apply_reset();
        cfg_write(4'h8, 32'h7);
        checks++;
        if ({sim_finish_o, test_pass_o} !== 2'b10) begin
            errors++;
            $display("FAIL fail_flags: got fin/pass=%b%b required 10", sim_finish_o, test_pass_o);
        end
        cfg_read(4'hC, rd);
        checks++;
        if (rd !== 32'h0000_001D) begin
            errors++;
            $display("FAIL fail_status: got %h required 0000001d", rd);
        end
        cfg_write(4'h8, 32'h1);
        cfg_read(4'hC, rd);
        checks++;
        if (rd !== 32'h0000_001D || test_pass_o !== 1'b0) begin
            errors++;
            $display("FAIL fail_oneshot: got %h pass=%b required 0000001d pass=0", rd, test_pass_o);
        end
        cfg_write(4'h0, 32'h4000);
        cfg_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL fail_frozen_begin: got %h required 00000000", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic        stable;
        int          waited;
        apply_reset();
        cfg_write(4'h0, 32'h2000);
        cfg_write(4'h4, 32'h2010);
        cfg_write(4'h8, 32'h1);
        waited = 0;
        while (got.size() < 1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        sig_ready_i = 1'b0;
        waited = 0;
        while (!sig_valid_o && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!sig_valid_o) begin
            errors++;
            $display("FAIL bp_valid_timeout: got valid=0 required 1 within 30 cycles");
        end
        d0     = sig_data_o;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sig_valid_o !== 1'b1 || sig_data_o !== d0 || mem_rd_o !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable || d0 !== 32'h2222_2222) begin
            errors++;
            $display("FAIL bp_hold: got stable=%b held=%h required stable=1 held=22222222",
                     stable, d0);
        end
        sig_ready_i = 1'b1;
        waited = 0;
        while (!dump_done_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (got.size() != 4 || got[0] !== 32'h1111_1111 || got[1] !== 32'h2222_2222 ||
            got[2] !== 32'h3333_3333 || got[3] !== 32'h4444_4444) begin
            errors++;
            $display("FAIL bp_stream: got %0d words required 11111111 22222222 33333333 44444444",
                     got.size());
        end
        checks++;
        if (n_rd != 4 || dump_done_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_reads: got reads=%0d done=%b required reads=4 done=1", n_rd, dump_done_o);
        end
    endtask

    task automatic test_empty_range();
        logic [31:0] b [2];
        logic [31:0] e [2];
        logic        d1, d2;
        b = '{32'h3000, 32'h3010};
        e = '{32'h3000, 32'h3000};
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            cfg_write(4'h0, b[k]);
            cfg_write(4'h4, e[k]);
            cfg_write(4'h8, 32'h1);
            d1 = dump_done_o;
            @(negedge clk);
            d2 = dump_done_o;
            checks++;
            if (d1 !== 1'b0 || d2 !== 1'b1) begin
                errors++;
                $display("FAIL empty%0d_done: got done@N+1=%b done@N+2=%b required 0 and 1", k, d1, d2);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (n_rd != 0 || got.size() != 0) begin
                errors++;
                $display("FAIL empty%0d_noreads: got reads=%0d words=%0d required 0 and 0",
                         k, n_rd, got.size());
            end
        end
    endtask

    task automatic test_addr_mask();
        logic [31:0] rd;
        apply_reset();
        cfg_write(4'h0, 32'hFFFE_2003);
        cfg_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0000_2000) begin
            errors++;
            $display("FAIL mask_begin: got %h required 00002000", rd);
        end
        cfg_write(4'h4, 32'hFFFF_FFFF);
        cfg_read(4'h4, rd);
        checks++;
        if (rd !== 32'h0001_FFFC) begin
            errors++;
            $display("FAIL mask_end: got %h required 0001fffc", rd);
        end
        cfg_read(4'h2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h required 00000000", rd);
        end
        // Same-cycle write and read: read returns the old value
        cfg_access(1'b1, 1'b1, 4'h0, 32'h0000_0500, rd);
        checks++;
        if (rd !== 32'h0000_2000 || cfg_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL rw_collision: got %h ack=%b required 00002000 ack=1", rd, cfg_ack_o);
        end
        cfg_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0000_0500) begin
            errors++;
            $display("FAIL rw_after: got %h required 00000500", rd);
        end
    endtask

    task automatic test_reset_mid_dump();
        int waited;
        apply_reset();
        cfg_write(4'h0, 32'h2000);
        cfg_write(4'h4, 32'h2010);
        hold_ack = 1'b1;
        cfg_write(4'h8, 32'h1);
        waited = 0;
        while (!mem_rd_o && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b0 || sig_valid_o !== 1'b0 || pending !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got rd=%b valid=%b pending=%b required 0 0 1",
                     mem_rd_o, sig_valid_o, pending);
        end
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg_ack_o, cfg_rdata_o, mem_rd_o, mem_addr_o, sig_valid_o, sig_data_o,
             sim_finish_o, test_pass_o, dump_done_o} !== 102'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got rd=%b addr=%h valid=%b fin=%b pass=%b done=%b required all 0",
                     mem_rd_o, mem_addr_o, sig_valid_o, sim_finish_o, test_pass_o, dump_done_o);
        end
        rst_i    = 1'b0;
        hold_ack = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({mem_rd_o, sig_valid_o, sig_data_o, sim_finish_o, dump_done_o} !== 36'd0 ||
            got.size() != 0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late_ack: got rd=%b valid=%b data=%h fin=%b done=%b words=%0d required all 0",
                     mem_rd_o, sig_valid_o, sig_data_o, sim_finish_o, dump_done_o, got.size());
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        cfg_addr_i   = '0;
        cfg_wr_i     = 1'b0;
        cfg_rd_i     = 1'b0;
        cfg_wdata_i  = '0;
        mem_accept_i = 1'b0;
        mem_ack_i    = 1'b0;
        mem_data_i   = '0;
        sig_ready_i  = 1'b1;

        test_reset();
        test_pass_path();
        test_fail_code();
        test_backpressure();
        test_empty_range();
        test_addr_mask();
        test_reset_mid_dump();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
